// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - HPDcache memory interface types shared by the write-path blocks
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_MEM_ADDR_WIDTH = 32;
    localparam int unsigned HPDCACHE_MEM_ID_WIDTH   = 4;
    localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 64;

    typedef logic [7:0]                               hpdcache_mem_len_t;
    typedef logic [2:0]                               hpdcache_mem_size_t;
    typedef logic [HPDCACHE_MEM_ID_WIDTH-1:0]         hpdcache_mem_id_t;
    typedef logic [HPDCACHE_MEM_ADDR_WIDTH-1:0]       hpdcache_mem_addr_t;
    typedef logic [HPDCACHE_MEM_DATA_WIDTH-1:0]       hpdcache_mem_data_t;
    typedef logic [HPDCACHE_MEM_DATA_WIDTH/8-1:0]     hpdcache_mem_be_t;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_READ   = 2'b00,
        HPDCACHE_MEM_WRITE  = 2'b01,
        HPDCACHE_MEM_ATOMIC = 2'b10
    } hpdcache_mem_command_e;

    typedef struct packed {
        hpdcache_mem_addr_t    mem_req_addr;
        hpdcache_mem_len_t     mem_req_len;
        hpdcache_mem_size_t    mem_req_size;
        hpdcache_mem_id_t      mem_req_id;
        hpdcache_mem_command_e mem_req_command;
        logic [3:0]            mem_req_atomic;
        logic                  mem_req_cacheable;
    } hpdcache_mem_req_t;

    typedef struct packed {
        hpdcache_mem_data_t mem_req_w_data;
        hpdcache_mem_be_t   mem_req_w_be;
        logic               mem_req_w_last;
    } hpdcache_mem_req_w_t;

    typedef struct packed {
        logic             mem_resp_w_is_atomic;
        logic [1:0]       mem_resp_w_error;
        hpdcache_mem_id_t mem_resp_w_id;
    } hpdcache_mem_resp_w_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// rtl/hpdcache_fifo_reg.sv - register-based FIFO with full/empty handshake flags
module hpdcache_fifo_reg #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type         fifo_data_t = logic
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       w_i,
    output logic       wok_o,
    input  fifo_data_t wdata_i,
    input  logic       r_i,
    output logic       rok_o,
    output fifo_data_t rdata_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    fifo_data_t    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push;
    logic          pop;

    assign wok_o   = (cnt_q != DEPTH_CNT);
    assign rok_o   = (cnt_q != '0);
    assign push    = w_i && wok_o;
    assign pop     = r_i && rok_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
            if (pop)  rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (!push && pop) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hpdcache_mem_write_flow_ctrl.sv
// rtl/hpdcache_mem_write_flow_ctrl.sv - write flow control: outstanding cap, W-after-AW, burst length check
module hpdcache_mem_write_flow_ctrl
    import hpdcache_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned MaxPendingAw   = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    output logic                                   req_ready_o,
    input  logic                                   req_valid_i,
    input  hpdcache_mem_req_t                      req_i,
    output logic                                   req_data_ready_o,
    input  logic                                   req_data_valid_i,
    input  hpdcache_mem_req_w_t                    req_data_i,
    input  logic                                   resp_ready_i,
    output logic                                   resp_valid_o,
    output hpdcache_mem_resp_w_t                   resp_o,
    input  logic                                   dn_req_ready_i,
    output logic                                   dn_req_valid_o,
    output hpdcache_mem_req_t                      dn_req_o,
    input  logic                                   dn_req_data_ready_i,
    output logic                                   dn_req_data_valid_o,
    output hpdcache_mem_req_w_t                    dn_req_data_o,
    output logic                                   dn_resp_ready_o,
    input  logic                                   dn_resp_valid_i,
    input  hpdcache_mem_resp_w_t                   dn_resp_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   busy_o,
    output logic                                   err_len_o
);

    localparam int unsigned OW = $clog2(MaxOutstanding + 1);
    localparam int unsigned AW = $clog2(MaxPendingAw + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MaxOutstanding);
    localparam logic [AW-1:0] AW_MAX  = AW'(MaxPendingAw);
    localparam hpdcache_mem_len_t BEAT_MAX = '1;

    logic [OW-1:0]     out_cnt_q;
    logic [AW-1:0]     aw_cnt_q;
    hpdcache_mem_len_t beat_cnt_q;
    logic              err_len_q;

    logic              allow;
    logic              wen;
    logic              req_hs;
    logic              beat_hs;
    logic              resp_hs;
    logic              last_beat;
    logic              last_hs;
    logic              len_bad;
    hpdcache_mem_len_t exp_len;
    logic              fifo_wok;
    logic              fifo_rok;

    assign allow          = (out_cnt_q < OUT_MAX) && (aw_cnt_q < AW_MAX);
    assign dn_req_valid_o = req_valid_i && allow;
    assign req_ready_o    = dn_req_ready_i && allow;
    assign dn_req_o       = req_i;
    assign req_hs         = req_valid_i && req_ready_o;

    // aw_cnt counts only requests registered in earlier cycles, so W trails its AW by a cycle.
    assign wen                 = (aw_cnt_q != '0);
    assign dn_req_data_valid_o = req_data_valid_i && wen;
    assign req_data_ready_o    = dn_req_data_ready_i && wen;
    assign dn_req_data_o       = req_data_i;
    assign beat_hs             = req_data_valid_i && req_data_ready_o;
    assign last_beat           = req_data_i.mem_req_w_last;
    assign last_hs             = beat_hs && last_beat;

    assign resp_valid_o    = dn_resp_valid_i;
    assign dn_resp_ready_o = resp_ready_i;
    assign resp_o          = dn_resp_i;
    assign resp_hs         = dn_resp_valid_i && resp_ready_i;

    // A burst of len+1 beats must raise last exactly on beat index len.
    assign len_bad = last_beat ? (beat_cnt_q != exp_len) : (beat_cnt_q == exp_len);

    hpdcache_fifo_reg #(
        .FIFO_DEPTH  (MaxPendingAw),
        .fifo_data_t (hpdcache_mem_len_t)
    ) len_fifo_i (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .w_i     (req_hs),
        .wok_o   (fifo_wok),
        .wdata_i (req_i.mem_req_len),
        .r_i     (last_hs),
        .rok_o   (fifo_rok),
        .rdata_o (exp_len)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_q  <= '0;
            aw_cnt_q   <= '0;
            beat_cnt_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            if (req_hs && !resp_hs)
                out_cnt_q <= out_cnt_q + OW'(1);
            else if (!req_hs && resp_hs && (out_cnt_q != '0))
                out_cnt_q <= out_cnt_q - OW'(1);

            if (req_hs && !last_hs)      aw_cnt_q <= aw_cnt_q + AW'(1);
            else if (!req_hs && last_hs) aw_cnt_q <= aw_cnt_q - AW'(1);

            if (beat_hs) begin
                if (last_beat)                 beat_cnt_q <= '0;
                else if (beat_cnt_q != BEAT_MAX) beat_cnt_q <= beat_cnt_q + 8'd1;
            end

            if (beat_hs && len_bad) err_len_q <= 1'b1;
        end
    end

    assign outstanding_o = out_cnt_q;
    assign busy_o        = (out_cnt_q != '0);
    assign err_len_o     = err_len_q;

    a_resp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_hs && !req_hs && (out_cnt_q == '0)));
    a_out_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_hs && !resp_hs && (out_cnt_q == OUT_MAX)));
    a_fifo_push_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_hs && !fifo_wok));
    a_fifo_pop_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(last_hs && !fifo_rok));

endmodule

// File: tb/tb_hpdcache_mem_write_flow_ctrl.sv
// tb/tb_hpdcache_mem_write_flow_ctrl.sv - self-checking bench with queue-based reference model
module tb_hpdcache_mem_write_flow_ctrl;
    import hpdcache_pkg::*;

    localparam int MO = 2;
    localparam int MP = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        req_ready, req_valid;
    hpdcache_mem_req_t           req;
    logic                        req_data_ready, req_data_valid;
    hpdcache_mem_req_w_t         req_data;
    logic                        resp_ready, resp_valid;
    hpdcache_mem_resp_w_t        resp;
    logic                        dn_req_ready, dn_req_valid;
    hpdcache_mem_req_t           dn_req;
    logic                        dn_req_data_ready, dn_req_data_valid;
    hpdcache_mem_req_w_t         dn_req_data;
    logic                        dn_resp_ready, dn_resp_valid;
    hpdcache_mem_resp_w_t        dn_resp;
    logic [$clog2(MO+1)-1:0]     outstanding;
    logic                        busy, err_len;

    int n_checks = 0;
    int n_errors = 0;

    int m_out;
    int m_q[$];
    int m_beat;
    bit m_err;
    bit m_req_hs;
    bit m_beat_hs;

    always #5 clk = ~clk;

    hpdcache_mem_write_flow_ctrl #(
        .MaxOutstanding (MO),
        .MaxPendingAw   (MP)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .req_ready_o         (req_ready),
        .req_valid_i         (req_valid),
        .req_i               (req),
        .req_data_ready_o    (req_data_ready),
        .req_data_valid_i    (req_data_valid),
        .req_data_i          (req_data),
        .resp_ready_i        (resp_ready),
        .resp_valid_o        (resp_valid),
        .resp_o              (resp),
        .dn_req_ready_i      (dn_req_ready),
        .dn_req_valid_o      (dn_req_valid),
        .dn_req_o            (dn_req),
        .dn_req_data_ready_i (dn_req_data_ready),
        .dn_req_data_valid_o (dn_req_data_valid),
        .dn_req_data_o       (dn_req_data),
        .dn_resp_ready_o     (dn_resp_ready),
        .dn_resp_valid_i     (dn_resp_valid),
        .dn_resp_i           (dn_resp),
        .outstanding_o       (outstanding),
        .busy_o              (busy),
        .err_len_o           (err_len)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare every output with the model at negedge, then advance the model at posedge.
    task automatic step();
        bit allow, wen, rhs, bhs, shs, is_last;
        @(negedge clk);
        allow = (m_out < MO) && (m_q.size() < MP);
        wen   = (m_q.size() != 0);
        check("dn_req_valid",      128'(dn_req_valid),      128'(req_valid && allow));
        check("req_ready",         128'(req_ready),         128'(dn_req_ready && allow));
        check("dn_req_data_valid", 128'(dn_req_data_valid), 128'(req_data_valid && wen));
        check("req_data_ready",    128'(req_data_ready),    128'(dn_req_data_ready && wen));
        check("resp_valid",        128'(resp_valid),        128'(dn_resp_valid));
        check("dn_resp_ready",     128'(dn_resp_ready),     128'(resp_ready));
        check("outstanding",       128'(outstanding),       128'(m_out));
        check("busy",              128'(busy),              128'(m_out != 0));
        check("err_len",           128'(err_len),           128'(m_err));
        check("dn_req",            128'(dn_req),            128'(req));
        check("dn_req_data",       128'(dn_req_data),       128'(req_data));
        check("resp",              128'(resp),              128'(dn_resp));
        rhs     = req_valid && dn_req_ready && allow;
        bhs     = req_data_valid && dn_req_data_ready && wen;
        shs     = dn_resp_valid && resp_ready;
        is_last = req_data.mem_req_w_last;
        @(posedge clk);
        if (!rst_n) begin
            m_out = 0;
            m_q.delete();
            m_beat = 0;
            m_err = 1'b0;
            m_req_hs = 1'b0;
            m_beat_hs = 1'b0;
        end else begin
            if (bhs) begin
                if (is_last != (m_beat == m_q[0])) m_err = 1'b1;
                if (is_last) begin
                    void'(m_q.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (rhs) m_q.push_back(int'(req.mem_req_len));
            m_out = m_out + int'(rhs) - int'(shs);
            m_req_hs = rhs;
            m_beat_hs = bhs;
        end
        #1;
    endtask

    task automatic set_req(input int len);
        req = '0;
        req.mem_req_addr    = $urandom;
        req.mem_req_len     = hpdcache_mem_len_t'(len);
        req.mem_req_size    = 3'd3;
        req.mem_req_id      = hpdcache_mem_id_t'($urandom);
        req.mem_req_command = HPDCACHE_MEM_WRITE;
        req_valid = 1'b1;
    endtask

    task automatic set_beat(input bit last);
        req_data.mem_req_w_data = {$urandom, $urandom};
        req_data.mem_req_w_be   = '1;
        req_data.mem_req_w_last = last;
        req_data_valid = 1'b1;
    endtask

    task automatic ret_b();
        dn_resp_valid = 1'b1;
        dn_resp = hpdcache_mem_resp_w_t'($urandom);
        step();
        dn_resp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req = '0;
        req_data_valid = 1'b0; req_data = '0;
        resp_ready = 1'b1;
        dn_req_ready = 1'b1; dn_req_data_ready = 1'b1;
        dn_resp_valid = 1'b0; dn_resp = '0;
        m_out = 0; m_beat = 0; m_err = 1'b0; m_req_hs = 1'b0; m_beat_hs = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_outstanding", 128'(outstanding), 128'(0));
        check("rst_busy",        128'(busy),        128'(0));
        check("rst_err",         128'(err_len),     128'(0));
        check("rst_data_ready",  128'(req_data_ready), 128'(0));

        // Outstanding cap of two, third request waits for a B.
        set_req(0); step();
        set_req(0); step();
        set_req(0); #1;
        check("cap_dn_req_valid", 128'(dn_req_valid), 128'(0));
        check("cap_req_ready",    128'(req_ready),    128'(0));
        check("cap_outstanding",  128'(outstanding),  128'(2));
        step();
        ret_b(); #1;
        check("cap_release_ready", 128'(req_ready), 128'(1));
        step();
        req_valid = 1'b0;
        repeat (3) begin set_beat(1'b1); step(); end
        req_data_valid = 1'b0;
        ret_b(); ret_b(); #1;
        check("cap_drained", 128'(outstanding), 128'(0));

        // Data presented ahead of its request is held back.
        set_beat(1'b1);
        repeat (3) begin step(); check("early_w_blocked", 128'(dn_req_data_valid), 128'(0)); end
        set_req(0); step();
        req_valid = 1'b0; #1;
        check("w_after_aw", 128'(dn_req_data_valid), 128'(1));
        step();
        req_data_valid = 1'b0; #1;
        check("w_after_aw_err", 128'(err_len), 128'(0));

        // Same-cycle request and B with one in flight.
        set_req(0); dn_resp_valid = 1'b1; step();
        req_valid = 1'b0; dn_resp_valid = 1'b0; #1;
        check("same_cycle_out", 128'(outstanding), 128'(1));
        set_beat(1'b1); step();
        req_data_valid = 1'b0;
        ret_b();

        // Four AWs pending without data, fifth waits for a last beat.
        repeat (4) begin set_req(0); step(); req_valid = 1'b0; ret_b(); end
        set_req(0); #1;
        check("aw_cap_ready", 128'(req_ready),    128'(0));
        check("aw_cap_valid", 128'(dn_req_valid), 128'(0));
        step();
        set_beat(1'b1); step();
        req_data_valid = 1'b0; #1;
        check("aw_release_ready", 128'(req_ready), 128'(1));
        step();
        req_valid = 1'b0;
        repeat (4) begin set_beat(1'b1); step(); end
        req_data_valid = 1'b0;
        ret_b();

        // len=3 burst terminated early on beat 2.
        set_req(3); step();
        req_valid = 1'b0;
        set_beat(1'b0); step();
        set_beat(1'b0); step();
        set_beat(1'b1); step();
        req_data_valid = 1'b0; #1;
        check("early_last_err", 128'(err_len), 128'(1));
        ret_b();
        repeat (3) step();
        check("err_sticky", 128'(err_len), 128'(1));

        // Reset in the middle of a burst, then a clean len=1 burst.
        set_req(3); step();
        req_valid = 1'b0;
        set_beat(1'b0); step();
        set_beat(1'b0); rst_n = 1'b0; step();
        rst_n = 1'b1; req_data_valid = 1'b0; #1;
        check("midrst_out",  128'(outstanding), 128'(0));
        check("midrst_busy", 128'(busy),        128'(0));
        check("midrst_err",  128'(err_len),     128'(0));
        set_req(1); step();
        req_valid = 1'b0;
        set_beat(1'b0); step();
        set_beat(1'b1); step();
        req_data_valid = 1'b0;
        ret_b(); #1;
        check("clean_out",  128'(outstanding), 128'(0));
        check("clean_busy", 128'(busy),        128'(0));
        check("clean_err",  128'(err_len),     128'(0));

        // Randomized traffic with occasional misplaced last and periodic resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 599) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                continue;
            end
            if (!req_valid || m_req_hs) begin
                if ($urandom_range(0, 1) == 1) set_req(int'($urandom_range(0, 3)));
                else req_valid = 1'b0;
            end
            if (!req_data_valid || m_beat_hs) begin
                if (m_q.size() != 0 && $urandom_range(0, 3) != 0)
                    set_beat((m_beat >= m_q[0]) ^ ($urandom_range(0, 39) == 0));
                else
                    req_data_valid = 1'b0;
            end
            dn_req_ready      = ($urandom_range(0, 3) != 0);
            dn_req_data_ready = ($urandom_range(0, 3) != 0);
            resp_ready        = ($urandom_range(0, 1) == 1);
            dn_resp_valid     = (m_out > 0) && ($urandom_range(0, 2) == 0);
            dn_resp           = hpdcache_mem_resp_w_t'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
